// File: rtl/lsu_mem.sv
// Memory-access stage: single-outstanding load/store over a valid/ready bus with load/store lane formatting.
// Optional misaligned-access trap enabled by defining LSU_MEM_MISALIGN_CHECK_EN.
module lsu_mem #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        inst_type_i,
    input  logic              rd_ena_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [2:0]        ls_sel_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic              mem_stall_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_wen_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    output logic [7:0]        req_wstrb_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    output logic              mem_stall_req_o,
    output logic [7:0]        inst_type_o,
    output logic              rd_ena_o,
    output logic [4:0]        rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              misalign_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_req_wen;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [STRB_W-1:0]   r_req_wstrb;
    logic [DATA_W-1:0]   r_load_data;

    logic                w_is_load;
    logic                w_is_store;
    logic                w_mem_op;
    logic                w_misalign;
    logic                w_fire;
    logic [5:0]          w_shamt;
    logic [STRB_W-1:0]   w_strb_base;
    logic [STRB_W-1:0]   w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_ld_raw;
    logic [DATA_W-1:0]   w_ld_data;

    // Load wins when both type bits are set
    assign w_is_load  = inst_type_i[1];
    assign w_is_store = inst_type_i[0] & ~inst_type_i[1];
    assign w_mem_op   = inst_type_i[1] | inst_type_i[0];
    assign w_shamt    = {ls_addr_i[2:0], 3'b000};

    // Store lane placement; bytes past the 8-byte line fall off the shift
    always_comb begin
        w_strb_base = STRB_W'(8'h01);
        case (ls_sel_i[1:0])
            2'b00:   w_strb_base = STRB_W'(8'h01);
            2'b01:   w_strb_base = STRB_W'(8'h03);
            2'b10:   w_strb_base = STRB_W'(8'h0F);
            default: w_strb_base = STRB_W'(8'hFF);
        endcase
    end
    assign w_wstrb = w_strb_base << ls_addr_i[2:0];
    assign w_wdata = rd_data_i << w_shamt;

    // Load lane extraction and sign/zero extension
    assign w_ld_raw = rsp_rdata_i >> w_shamt;
    always_comb begin
        w_ld_data = '0;
        case (ls_sel_i)
            3'b000:  w_ld_data = {{(DATA_W-8){w_ld_raw[7]}},   w_ld_raw[7:0]};
            3'b001:  w_ld_data = {{(DATA_W-16){w_ld_raw[15]}}, w_ld_raw[15:0]};
            3'b010:  w_ld_data = {{(DATA_W-32){w_ld_raw[31]}}, w_ld_raw[31:0]};
            3'b011:  w_ld_data = w_ld_raw;
            3'b100:  w_ld_data = {{(DATA_W-8){1'b0}},  w_ld_raw[7:0]};
            3'b101:  w_ld_data = {{(DATA_W-16){1'b0}}, w_ld_raw[15:0]};
            3'b110:  w_ld_data = {{(DATA_W-32){1'b0}}, w_ld_raw[31:0]};
            default: w_ld_data = '0;
        endcase
    end

`ifdef LSU_MEM_MISALIGN_CHECK_EN
    logic w_unaligned;
    always_comb begin
        w_unaligned = 1'b0;
        case (ls_sel_i[1:0])
            2'b01:   w_unaligned = ls_addr_i[0];
            2'b10:   w_unaligned = |ls_addr_i[1:0];
            2'b11:   w_unaligned = |ls_addr_i[2:0];
            default: w_unaligned = 1'b0;
        endcase
    end
    assign w_misalign = (r_state == IDLE) & w_mem_op & w_unaligned;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fire = (r_state == IDLE) & w_mem_op & ~w_misalign;

    // State and request/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_wen   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_fire) begin
                r_req_wen   <= w_is_store;
                r_req_addr  <= {ls_addr_i[ADDR_W-1:3], 3'b000};
                r_req_wdata <= w_is_store ? w_wdata : '0;
                r_req_wstrb <= w_is_store ? w_wstrb : '0;
            end
            if ((r_state == WAIT) && rsp_valid_i) begin
                r_load_data <= w_ld_data;
            end
        end
    end

    // Next state and stage outputs
    always_comb begin
        w_next          = r_state;
        req_valid_o     = 1'b0;
        mem_stall_req_o = 1'b0;
        rd_ena_o        = 1'b0;
        rd_data_o       = rd_data_i;
        inst_type_o     = inst_type_i;
        case (r_state)
            IDLE: begin
                if (w_misalign) begin
                    inst_type_o = 8'h00;
                end else if (w_mem_op) begin
                    mem_stall_req_o = 1'b1;
                    w_next          = REQ;
                end else begin
                    rd_ena_o = rd_ena_i;
                end
            end
            REQ: begin
                req_valid_o     = 1'b1;
                mem_stall_req_o = 1'b1;
                if (req_ready_i) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                mem_stall_req_o = 1'b1;
                if (rsp_valid_i) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_is_load) begin
                    rd_ena_o  = rd_ena_i;
                    rd_data_o = r_load_data;
                end
                if (!mem_stall_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign req_wen_o   = r_req_wen;
    assign req_addr_o  = r_req_addr;
    assign req_wdata_o = r_req_wdata;
    assign req_wstrb_o = r_req_wstrb;
    assign rd_addr_o   = rd_addr_i;
    assign misalign_o  = w_misalign;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: reset, load formatting, stores with backpressure, pass-through, mid-op reset.
module tb_lsu_mem;

    logic        clk;
    logic        rst;
    logic [7:0]  inst_type_i;
    logic        rd_ena_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] rd_data_i;
    logic [2:0]  ls_sel_i;
    logic [63:0] ls_addr_i;
    logic        mem_stall_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_wen_o;
    logic [63:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        rsp_valid_i;
    logic [63:0] rsp_rdata_i;
    logic        mem_stall_req_o;
    logic [7:0]  inst_type_o;
    logic        rd_ena_o;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .inst_type_i(inst_type_i), .rd_ena_i(rd_ena_i), .rd_addr_i(rd_addr_i),
        .rd_data_i(rd_data_i), .ls_sel_i(ls_sel_i), .ls_addr_i(ls_addr_i),
        .mem_stall_i(mem_stall_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_wen_o(req_wen_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o),
        .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i),
        .mem_stall_req_o(mem_stall_req_o), .inst_type_o(inst_type_o),
        .rd_ena_o(rd_ena_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_type_i = 8'h00; rd_ena_i = 1'b0; rd_addr_i = 5'd0; rd_data_i = 64'h0;
        ls_sel_i = 3'b000; ls_addr_i = 64'h0; mem_stall_i = 1'b0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = 64'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if ({req_valid_o, req_wen_o, req_wstrb_o, mem_stall_req_o, rd_ena_o, misalign_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid=%b wen=%b wstrb=%h stall=%b rd_ena=%b mis=%b, expected all 0",
                     req_valid_o, req_wen_o, req_wstrb_o, mem_stall_req_o, rd_ena_o, misalign_o);
        end
        n_checks++;
        if ({req_addr_o, req_wdata_o, rd_data_o} !== 192'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h rd_data=%h, expected 0", req_addr_o, req_wdata_o, rd_data_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Load with ready=1 and response one cycle after accept; checks every cycle of the 4-cycle sequence
    task automatic do_load(input logic [2:0] sel, input logic [63:0] addr, input logic [63:0] rdata,
                           input logic [63:0] exp, input string nm);
        inst_type_i = 8'h02; rd_ena_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 64'hAAAA_BBBB_CCCC_DDDD;
        ls_sel_i = sel; ls_addr_i = addr; req_ready_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_c0: stall/valid/rd_ena=%b%b%b, expected 100", nm, mem_stall_req_o, req_valid_o, rd_ena_o);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, req_wen_o, req_wstrb_o, rd_ena_o} !== {3'b110, 8'h00, 1'b0}
            || req_addr_o !== {addr[63:3], 3'b000}) begin
            n_fail++;
            $display("FAIL %s_c1: stall=%b valid=%b wen=%b wstrb=%h rd_ena=%b addr=%h, expected 1 1 0 00 0 %h",
                     nm, mem_stall_req_o, req_valid_o, req_wen_o, req_wstrb_o, rd_ena_o, req_addr_o, {addr[63:3], 3'b000});
        end
        step();
        req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_rdata_i = rdata;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_c2: stall/valid/rd_ena=%b%b%b, expected 100", nm, mem_stall_req_o, req_valid_o, rd_ena_o);
        end
        step();
        rsp_valid_i = 1'b0; rsp_rdata_i = 64'h0;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b001 || rd_addr_o !== 5'd5 || rd_data_o !== exp) begin
            n_fail++;
            $display("FAIL %s_c3: stall=%b valid=%b rd_ena=%b rd_addr=%0d rd_data=%h, expected 0 0 1 5 %h",
                     nm, mem_stall_req_o, req_valid_o, rd_ena_o, rd_addr_o, rd_data_o, exp);
        end
        clear_inputs();
        step();
    endtask

    // Store with ready held low for n_low request cycles; checks request stability and DONE hold
    task automatic do_store(input logic [2:0] sel, input logic [63:0] addr, input logic [63:0] data,
                            input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb, input int n_low,
                            input string nm);
        inst_type_i = 8'h01; rd_ena_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = data;
        ls_sel_i = sel; ls_addr_i = addr; req_ready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_c0: stall/valid/rd_ena=%b%b%b, expected 100", nm, mem_stall_req_o, req_valid_o, rd_ena_o);
        end
        step();
        for (int i = 0; i <= n_low; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_stall_req_o, req_valid_o, req_wen_o} !== 3'b111 || req_addr_o !== {addr[63:3], 3'b000}
                || req_wdata_o !== exp_wdata || req_wstrb_o !== exp_wstrb) begin
                n_fail++;
                $display("FAIL %s_req%0d: stall=%b valid=%b wen=%b addr=%h wdata=%h wstrb=%h, expected 1 1 1 %h %h %h",
                         nm, i, mem_stall_req_o, req_valid_o, req_wen_o, req_addr_o, req_wdata_o, req_wstrb_o,
                         {addr[63:3], 3'b000}, exp_wdata, exp_wstrb);
            end
            if (i == n_low) req_ready_i = 1'b1;
            step();
        end
        req_ready_i = 1'b0; rsp_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_wait: stall/valid=%b%b, expected 10", nm, mem_stall_req_o, req_valid_o);
        end
        step();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s_done: stall/valid/rd_ena=%b%b%b, expected 000", nm, mem_stall_req_o, req_valid_o, rd_ena_o);
        end
        mem_stall_i = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s_hold: stall/valid/rd_ena=%b%b%b, expected 000 while held in DONE",
                     nm, mem_stall_req_o, req_valid_o, rd_ena_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_formats();
        do_load(3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, "ld");
        do_load(3'b000, 64'h8000_0003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, "lb3");
        do_load(3'b000, 64'h8000_0002, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FFFF, "lb2");
        do_load(3'b100, 64'h8000_0002, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_00FF, "lbu2");
        do_load(3'b000, 64'h8000_0000, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0000, "lb0");
        do_load(3'b001, 64'h8000_0002, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF, "lh2");
        do_load(3'b010, 64'h8000_0000, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_80FF_0000, "lw0");
        do_load(3'b110, 64'h8000_0000, 64'h0000_0000_80FF_0000, 64'h0000_0000_80FF_0000, "lwu0");
        do_load(3'b101, 64'h8000_0006, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD, "lhu6");
        do_load(3'b111, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "sel7");
    endtask

    task automatic test_store();
        do_store(3'b010, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'hDEAD_BEEF_0000_0000, 8'hF0, 3, "sw");
        do_store(3'b000, 64'h8000_0007, 64'h1234_5678_9ABC_DE5A, 64'h5A00_0000_0000_0000, 8'h80, 0, "sb7");
        do_store(3'b001, 64'h8000_0002, 64'h0000_0000_0000_CAFE, 64'h0000_0000_CAFE_0000, 8'h0C, 1, "sh2");
    endtask

    task automatic test_passthrough();
        inst_type_i = 8'h10; rd_ena_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        n_checks++;
        if ({mem_stall_req_o, req_valid_o, rd_ena_o} !== 3'b001 || rd_addr_o !== 5'd7
            || rd_data_o !== 64'h0123_4567_89AB_CDEF || inst_type_o !== 8'h10) begin
            n_fail++;
            $display("FAIL pass_a: stall=%b valid=%b rd_ena=%b rd_addr=%0d rd_data=%h type=%h, expected 0 0 1 7 0123456789abcdef 10",
                     mem_stall_req_o, req_valid_o, rd_ena_o, rd_addr_o, rd_data_o, inst_type_o);
        end
        rd_ena_i = 1'b0; rd_data_i = 64'h55;
        #1;
        n_checks++;
        if (rd_ena_o !== 1'b0 || rd_data_o !== 64'h55) begin
            n_fail++;
            $display("FAIL pass_b: rd_ena=%b rd_data=%h, expected 0 0000000000000055", rd_ena_o, rd_data_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_op();
        inst_type_i = 8'h02; rd_ena_i = 1'b1; rd_addr_i = 5'd3; ls_sel_i = 3'b011;
        ls_addr_i = 64'h8000_0020; req_ready_i = 1'b1;
        step();
        step();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0; rsp_valid_i = 1'b1; rsp_rdata_i = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        n_checks++;
        if ({req_valid_o, mem_stall_req_o, rd_ena_o, req_wstrb_o} !== 11'h000
            || req_addr_o !== 64'h0 || rd_data_o !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b stall=%b rd_ena=%b wstrb=%h addr=%h rd_data=%h, expected all 0",
                     req_valid_o, mem_stall_req_o, rd_ena_o, req_wstrb_o, req_addr_o, rd_data_o);
        end
        step();
        rsp_valid_i = 1'b0; rsp_rdata_i = 64'h0;
        @(negedge clk);
        n_checks++;
        if ({req_valid_o, mem_stall_req_o, rd_ena_o} !== 3'b000 || rd_data_o !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_stale: valid=%b stall=%b rd_ena=%b rd_data=%h, expected 0 0 0 0",
                     req_valid_o, mem_stall_req_o, rd_ena_o, rd_data_o);
        end
        step();
    endtask

    task automatic test_misalign();
`ifdef LSU_MEM_MISALIGN_CHECK_EN
        inst_type_i = 8'h02; rd_ena_i = 1'b1; rd_addr_i = 5'd4; ls_sel_i = 3'b010;
        ls_addr_i = 64'h8000_0002; req_ready_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({misalign_o, req_valid_o, mem_stall_req_o, rd_ena_o} !== 4'b1000 || inst_type_o !== 8'h00) begin
            n_fail++;
            $display("FAIL misalign_a: mis=%b valid=%b stall=%b rd_ena=%b type=%h, expected 1 0 0 0 00",
                     misalign_o, req_valid_o, mem_stall_req_o, rd_ena_o, inst_type_o);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({misalign_o, req_valid_o, mem_stall_req_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL misalign_b: mis=%b valid=%b stall=%b, expected 1 0 0", misalign_o, req_valid_o, mem_stall_req_o);
        end
        clear_inputs();
        step();
`else
        inst_type_i = 8'h02; ls_sel_i = 3'b010; ls_addr_i = 64'h8000_0002;
        #1;
        n_checks++;
        if ({misalign_o, mem_stall_req_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL misalign_off: mis=%b stall=%b, expected 0 1", misalign_o, mem_stall_req_o);
        end
        clear_inputs();
        do_load(3'b010, 64'h8000_0002, 64'h1122_3344_5566_7788, 64'h0000_0000_3344_5566, "lw_mis");
        do_store(3'b011, 64'h8000_0004, 64'h1111_2222_3333_4444, 64'h3333_4444_0000_0000, 8'hF0, 0, "sd_mis");
`endif
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_formats();
        test_store();
        test_passthrough();
        test_reset_mid_op();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
